// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encoding, default parameter values and sizing helper.
package pll_seq_pkg;
  typedef enum logic [2:0] {RST_HOLD, WAIT_LOCK, SETTLE, ENABLE, RUN, FAIL} state_t;
  localparam int N_CLK_DEF = 3;
  localparam int RST_CYCLES_DEF = 16;
  localparam int LOCK_TIMEOUT_DEF = 50000;
  localparam int SETTLE_CYCLES_DEF = 1024;
  localparam int GAP_CYCLES_DEF = 8;
  localparam int MAX_RETRY_DEF = 3;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-FF synchronizer bringing the asynchronous PLL lock into the clkin domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_clk_sequencer.sv
// pll_clk_sequencer: PLL power-up/recovery sequencer (reset, lock wait, settle, staged enables).
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_clk_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_CLK = N_CLK_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             restart,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [N_CLK-1:0] enclk,
  output logic             ready,
  output logic             fail,
  output logic [7:0]       loss_cnt
);
  localparam int CW = $clog2(max4(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, GAP_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry, retry_n;
  logic [N_CLK-1:0] enclk_n;
  logic lock_s;
  pll_lock_sync u_sync (.clk(clkin), .rst(reset), .d(pll_lock), .q(lock_s));
  always_ff @(posedge clkin)
    if (reset) begin
      state <= RST_HOLD;
      cnt <= '0;
      retry <= '0;
      enclk <= '0;
      ready <= 1'b0;
      fail <= 1'b0;
      pll_reset <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      retry <= retry_n;
      enclk <= enclk_n;
      ready <= state_n == RUN;
      fail <= state_n == FAIL;
      pll_reset <= state_n == RST_HOLD || state_n == FAIL;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    retry_n = retry;
    enclk_n = enclk;
    case (state)
      RST_HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_n = cnt + 1'b1;
        if (lock_s) begin
          state_n = SETTLE;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_n = retry + 1'b1;
          state_n = (retry_n == RW'(MAX_RETRY)) ? FAIL : RST_HOLD;
          cnt_n = '0;
        end
      end
      SETTLE: begin
        cnt_n = lock_s ? cnt + 1'b1 : '0;
        if (lock_s && cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_n = ENABLE;
          cnt_n = '0;
          enclk_n = N_CLK'(1);
        end
      end
      ENABLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_n = '0;
          if (enclk[N_CLK-1]) begin
            state_n = RUN;
            retry_n = '0;
          end else enclk_n = N_CLK'({enclk, 1'b1});
        end
      end
      default: ;
    endcase
    // Lock loss tears all enables down together; restart overrides everything.
    if ((state == ENABLE || state == RUN) && !lock_s) begin
      state_n = RST_HOLD;
      cnt_n = '0;
      enclk_n = '0;
    end
    if (restart) begin
      state_n = RST_HOLD;
      cnt_n = '0;
      retry_n = '0;
      enclk_n = '0;
    end
  end
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic loss;
  assign loss = (state == ENABLE || state == RUN) && !lock_s && !restart;
  always_ff @(posedge clkin)
    if (reset) loss_cnt <= '0;
    else if (loss && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 1'b1;
`else
  assign loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pll_clk_sequencer.sv
// tb_pll_clk_sequencer: directed + randomized bench with a phase/elapsed-time reference model.
module tb_pll_clk_sequencer;
  localparam int N = 3, RC = 4, TO = 100, SC = 10, GAP = 2, MR = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, pll_lock = 1'b0;
  logic pll_reset, ready, fail;
  logic [N-1:0] enclk;
  logic [7:0] loss_cnt;
  int checks = 0, failures = 0, cyc = 0;
  pll_clk_sequencer #(.N_CLK(N), .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .SETTLE_CYCLES(SC),
    .GAP_CYCLES(GAP), .MAX_RETRY(MR)) dut (.clkin(clk), .reset(reset), .restart(restart),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .enclk(enclk), .ready(ready), .fail(fail),
    .loss_cnt(loss_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 50) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask
  // Model: phase 0 hold,1 wait,2 settle,3 enable,4 run,5 fail; t = cycles elapsed in phase.
  int m_ph, m_t, m_retry, m_loss;
  logic s1, s2, ls;
  function automatic logic [N-1:0] m_enclk();
    int on;
    on = m_ph == 4 ? N : (m_ph == 3 ? m_t / GAP + 1 : 0);
    return N'((1 << on) - 1);
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ph = 0; m_t = 0; m_retry = 0; m_loss = 0; s1 = 0; s2 = 0;
    end else begin
      ls = s2; s2 = s1; s1 = pll_lock;
      if (restart) begin
        m_ph = 0; m_t = 0; m_retry = 0;
      end else if ((m_ph == 3 || m_ph == 4) && !ls) begin
        m_ph = 0; m_t = 0;
        if (LC && m_loss < 255) m_loss++;
      end else case (m_ph)
        0: begin m_t++; if (m_t == RC) begin m_ph = 1; m_t = 0; end end
        1: if (ls) begin m_ph = 2; m_t = 0; end
           else begin
             m_t++;
             if (m_t == TO) begin m_retry++; m_t = 0; m_ph = m_retry == MR ? 5 : 0; end
           end
        2: begin m_t = ls ? m_t + 1 : 0; if (m_t == SC) begin m_ph = 3; m_t = 0; end end
        3: begin m_t++; if (m_t == N * GAP) begin m_ph = 4; m_retry = 0; end end
        default: ;
      endcase
    end
    #1;
    chk("pll_reset", pll_reset, m_ph == 0 || m_ph == 5);
    chk("fail", fail, m_ph == 5);
    chk("ready", ready, m_ph == 4);
    chk("enclk", enclk, m_enclk());
    chk("loss_cnt", loss_cnt, m_loss);
  end
  // which: 0..2 enclk bit, 3 ready, 4 fail, 5 enables+ready all low, 6 pll_reset low
  task automatic wait_sig(input int which, input int budget, output int at);
    logic hit;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      case (which)
        0, 1, 2: hit = enclk[which];
        3: hit = ready;
        4: hit = fail;
        5: hit = enclk == '0 && !ready;
        default: hit = !pll_reset;
      endcase
      if (hit) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL wait_timeout sel=%0d at cycle %0d: condition not reached in %0d cycles", which, cyc, budget);
    end
  endtask
  int r0, e0, a, at;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pll_reset", pll_reset, 1);
    chk("reset_enclk", enclk, 0);
    chk("reset_loss_cnt", loss_cnt, 0);
    reset = 1'b0; r0 = cyc;
    // power-up
    wait_sig(6, 20, at); chk("rst_hold_len", at - r0, 4);
    while (cyc < r0 + 20) @(negedge clk);
    e0 = cyc; pll_lock = 1'b1;
    wait_sig(0, 40, at); chk("enclk0_edge", at - e0, 13);
    wait_sig(1, 40, at); chk("enclk1_edge", at - e0, 15);
    wait_sig(2, 40, at); chk("enclk2_edge", at - e0, 17);
    wait_sig(3, 40, at); chk("ready_edge", at - e0, 19);
    // lock loss in RUN
    @(negedge clk); e0 = cyc; pll_lock = 1'b0;
    wait_sig(5, 10, at); chk("loss_teardown_edge", at - e0, 3);
    chk("loss_pll_reset", pll_reset, 1);
    chk("loss_cnt_one", loss_cnt, LC ? 1 : 0);
    @(negedge clk); pll_lock = 1'b1;
    wait_sig(3, 100, at);
    // restart mid-ENABLE coinciding with lock loss
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    wait_sig(0, 60, a);
    @(negedge clk); pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk); restart = 1'b1;
    chk("mid_enable_enclk", enclk, 3'b011);
    @(posedge clk); #1;
    chk("restart_enclk", enclk, 0);
    chk("restart_ready", ready, 0);
    chk("restart_loss_cnt", loss_cnt, LC ? 1 : 0);
    @(negedge clk); restart = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("restart_hold_4th", pll_reset, 1);
    @(posedge clk); #1;
    chk("restart_hold_end", pll_reset, 0);
    // no lock: two timeouts then FAIL
    wait_sig(4, 300, at); chk("fail_edge", at - (a + 7), 204);
    chk("fail_pll_reset", pll_reset, 1);
    @(negedge clk); restart = 1'b1;
    @(posedge clk); #1;
    chk("restart_fail_clr", fail, 0);
    chk("restart_fail_rst", pll_reset, 1);
    @(negedge clk); restart = 1'b0;
    // settle glitch at settle count 7
    repeat (8) @(negedge clk);
    e0 = cyc; pll_lock = 1'b1;
    repeat (8) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk); pll_lock = 1'b1;
    wait_sig(0, 40, at); chk("glitch_enclk0_edge", at - e0, 21);
    chk("glitch_loss_cnt", loss_cnt, LC ? 1 : 0);
    wait_sig(3, 40, at);
    // randomized lock behaviour and restarts
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) pll_lock = !pll_lock;
      restart = $urandom_range(0, 249) == 0;
    end
    @(negedge clk); restart = 1'b1; pll_lock = 1'b1;
    @(negedge clk); restart = 1'b0;
    wait_sig(3, 100, at);
    // loss counter saturation
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      pll_lock = 1'b1;
      wait_sig(0, 60, at);
    end
    @(posedge clk); #1;
    chk("loss_cnt_sat", loss_cnt, LC ? 255 : 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("final_reset_loss_cnt", loss_cnt, 0);
    chk("final_reset_pll_reset", pll_reset, 1);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
